// File: rtl/multi_dataflow_mac_lanes.sv
// Three FIFO-buffered input streams feeding a multi-lane signed dot-product engine with backpressured output.
// Define MULTI_DATAFLOW_MAC_LANES_MONITOR_EN to add the mon_vec_count / mon_drop_count ports.

module multi_dataflow_mac_lanes_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  output logic         full,
  input  logic         rd,
  output logic [W-1:0] rdata,
  output logic         valid
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          push, pop;

  assign valid = (count_q != '0);
  assign rdata = mem[rd_ptr_q];
  assign full  = full_q;

  // full is registered, so a write on a full FIFO is refused even if a pop frees a slot that cycle
  always_comb begin
    push     = wr && !full_q;
    pop      = rd && valid;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    full_d   = (count_d == (AW+1)'(DEPTH));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= wdata;
  end
endmodule

module multi_dataflow_mac_lanes #(
  parameter int LANES      = 2,
  parameter int DATA_W     = 32,
  parameter int ACC_W      = 64,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [LANES*DATA_W-1:0] inStream0_data,
  input  logic                    inStream0_wr,
  output logic                    inStream0_full,
  input  logic [LANES*DATA_W-1:0] inStream1_data,
  input  logic                    inStream1_wr,
  output logic                    inStream1_full,
  input  logic [DATA_W-1:0]       inStream2_data,
  input  logic                    inStream2_wr,
  output logic                    inStream2_full,
  output logic [DATA_W-1:0]       outStream0_data,
  output logic                    outStream0_wr,
  input  logic                    outStream0_full,
  input  logic [31:0]             reg_simple_mul,
  input  logic [7:0]              reg_shift,
  input  logic [15:0]             reg_len,
  output logic                    busy
`ifdef MULTI_DATAFLOW_MAC_LANES_MONITOR_EN
  ,
  output logic [31:0]             mon_vec_count,
  output logic [31:0]             mon_drop_count
`endif
);
  typedef enum logic [1:0] {IDLE, LOAD, ACC, OUT} state_t;

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d, beat_sum;
  logic [15:0]               cnt_q, cnt_d, len_q, len_d;
  logic [7:0]                shift_q, shift_d;
  logic [31:0]               mul_q, mul_d;
  logic [DATA_W-1:0]         data_q, data_d;
  logic [ACC_W-1:0]          shifted;
  logic [LANES*DATA_W-1:0]   a_rdata, b_rdata;
  logic [DATA_W-1:0]         c_rdata;
  logic                      a_valid, b_valid, c_valid;
  logic                      pop_a, pop_b, pop_c, use_mul, beat;
  logic signed [ACC_W-1:0]   prod [LANES];

  multi_dataflow_mac_lanes_fifo #(.W(LANES*DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clock(clock), .reset(reset), .wr(inStream0_wr), .wdata(inStream0_data),
    .full(inStream0_full), .rd(pop_a), .rdata(a_rdata), .valid(a_valid));
  multi_dataflow_mac_lanes_fifo #(.W(LANES*DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clock(clock), .reset(reset), .wr(inStream1_wr), .wdata(inStream1_data),
    .full(inStream1_full), .rd(pop_b), .rdata(b_rdata), .valid(b_valid));
  multi_dataflow_mac_lanes_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_c (
    .clock(clock), .reset(reset), .wr(inStream2_wr), .wdata(inStream2_data),
    .full(inStream2_full), .rd(pop_c), .rdata(c_rdata), .valid(c_valid));

  assign use_mul = (mul_q != 32'd0);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [DATA_W-1:0] a_el, m_el;
      assign a_el     = a_rdata[gi*DATA_W +: DATA_W];
      assign m_el     = use_mul ? mul_q[DATA_W-1:0] : b_rdata[gi*DATA_W +: DATA_W];
      assign prod[gi] = ACC_W'(a_el) * ACC_W'(m_el);
    end
  endgenerate

  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < LANES; i++) beat_sum = beat_sum + prod[i];
  end

  // shift amounts at or beyond the accumulator width collapse to the sign
  function automatic logic [ACC_W-1:0] sra(input logic signed [ACC_W-1:0] v, input logic [7:0] sh);
    if (int'(sh) >= ACC_W) sra = {ACC_W{v[ACC_W-1]}};
    else                   sra = v >>> sh;
  endfunction

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    shift_d = shift_q;
    mul_d   = mul_q;
    data_d  = data_q;
    pop_a   = 1'b0;
    pop_b   = 1'b0;
    pop_c   = 1'b0;
    beat    = a_valid && (use_mul || b_valid);
    case (state_q)
      IDLE: if (c_valid) begin
        pop_c   = 1'b1;
        acc_d   = ACC_W'($signed(c_rdata));
        len_d   = reg_len;
        shift_d = reg_shift;
        mul_d   = reg_simple_mul;
        cnt_d   = '0;
        state_d = LOAD;
      end
      LOAD: state_d = (len_q != 16'd0) ? ACC : OUT;
      ACC: if (beat) begin
        pop_a   = 1'b1;
        pop_b   = !use_mul;
        acc_d   = acc_q + beat_sum;
        cnt_d   = cnt_q + 16'd1;
        if (cnt_q == len_q - 16'd1) state_d = OUT;
      end
      OUT: if (!outStream0_full) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // result is captured once on entry to OUT and held through any backpressure
    shifted = sra(acc_d, shift_q);
    if (state_d == OUT && state_q != OUT) data_d = shifted[DATA_W-1:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      shift_q <= '0;
      mul_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      shift_q <= shift_d;
      mul_q   <= mul_d;
      data_q  <= data_d;
    end
  end

  assign outStream0_data = data_q;
  assign outStream0_wr   = (state_q == OUT) && !outStream0_full;
  assign busy            = (state_q != IDLE);

`ifdef MULTI_DATAFLOW_MAC_LANES_MONITOR_EN
  logic [31:0] vec_cnt_q, vec_cnt_d, drop_cnt_q, drop_cnt_d;
  logic        drop;

  always_comb begin
    drop       = (inStream0_wr && inStream0_full) || (inStream1_wr && inStream1_full) ||
                 (inStream2_wr && inStream2_full);
    vec_cnt_d  = vec_cnt_q + 32'(outStream0_wr);
    drop_cnt_d = drop_cnt_q + 32'(drop);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vec_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      vec_cnt_q  <= vec_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign mon_vec_count  = vec_cnt_q;
  assign mon_drop_count = drop_cnt_q;
`endif
endmodule

// File: tb/tb_multi_dataflow_mac_lanes.sv
// Bench for multi_dataflow_mac_lanes: directed cases plus random vectors against a dot-product reference model.
// Monitor checks are included when MULTI_DATAFLOW_MAC_LANES_MONITOR_EN is defined.

module tb_multi_dataflow_mac_lanes;
  localparam int LANES = 2;
  localparam int DW    = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic [LANES*DW-1:0] inStream0_data, inStream1_data;
  logic              inStream0_wr, inStream1_wr, inStream2_wr;
  logic              inStream0_full, inStream1_full, inStream2_full;
  logic [DW-1:0]     inStream2_data, outStream0_data;
  logic              outStream0_wr, outStream0_full;
  logic [31:0]       reg_simple_mul;
  logic [7:0]        reg_shift;
  logic [15:0]       reg_len;
  logic              busy;
`ifdef MULTI_DATAFLOW_MAC_LANES_MONITOR_EN
  logic [31:0]       mon_vec_count, mon_drop_count;
`endif

  multi_dataflow_mac_lanes #(.LANES(LANES), .DATA_W(DW), .ACC_W(64), .FIFO_DEPTH(64)) dut (
    .clock(clock), .reset(reset),
    .inStream0_data(inStream0_data), .inStream0_wr(inStream0_wr), .inStream0_full(inStream0_full),
    .inStream1_data(inStream1_data), .inStream1_wr(inStream1_wr), .inStream1_full(inStream1_full),
    .inStream2_data(inStream2_data), .inStream2_wr(inStream2_wr), .inStream2_full(inStream2_full),
    .outStream0_data(outStream0_data), .outStream0_wr(outStream0_wr), .outStream0_full(outStream0_full),
    .reg_simple_mul(reg_simple_mul), .reg_shift(reg_shift), .reg_len(reg_len),
    .busy(busy)
`ifdef MULTI_DATAFLOW_MAC_LANES_MONITOR_EN
    , .mon_vec_count(mon_vec_count), .mon_drop_count(mon_drop_count)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // output monitor: every strobe is logged with the cycle it occurred in
  logic [31:0] got_q[$];
  int strobe_cyc = 0;
  int n_strobes  = 0;
  always @(negedge clock) begin
    if (outStream0_wr) begin
      got_q.push_back(outStream0_data);
      strobe_cyc = cyc;
      n_strobes++;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  int va[$];
  int vb[$];
  int last_wr_cyc = 0;

  // reference: d = (c + sum of a*m over all elements) >>> shift, 64-bit wrapping
  function automatic logic [31:0] model(input int len, input int sh, input logic [31:0] mul, input int c);
    longint acc;
    logic [63:0] r;
    acc = longint'(c);
    for (int k = 0; k < len * LANES; k++)
      acc += longint'(va[k]) * ((mul != 0) ? longint'($signed(mul)) : longint'(vb[k]));
    acc = (sh >= 64) ? (acc >>> 63) : (acc >>> sh);
    r = acc;
    return r[31:0];
  endfunction

  task automatic send_vector(input int len, input int nbeats, input int sh, input logic [31:0] mul,
                             input int c, input bit scramble);
    reg_len        = 16'(len);
    reg_shift      = 8'(sh);
    reg_simple_mul = mul;
    inStream2_data = c;
    inStream2_wr   = 1'b1;
    tick;
    inStream2_wr   = 1'b0;
    last_wr_cyc    = cyc;
    tick;
    if (scramble) begin
      reg_len        = 16'($urandom);
      reg_shift      = 8'($urandom);
      reg_simple_mul = $urandom;
    end
    for (int k = 0; k < nbeats; k++) begin
      for (int l = 0; l < LANES; l++) begin
        inStream0_data[l*DW +: DW] = va[k*LANES+l];
        inStream1_data[l*DW +: DW] = vb[k*LANES+l];
      end
      inStream0_wr = 1'b1;
      inStream1_wr = (mul == 0);
      tick;
      last_wr_cyc = cyc;
    end
    inStream0_wr = 1'b0;
    inStream1_wr = 1'b0;
  endtask

  task automatic wait_result(input bit bp, output logic [31:0] d);
    int w = 0;
    while (got_q.size() == 0 && w < 300) begin
      if (bp) outStream0_full = 1'($urandom_range(0, 1));
      tick;
      w++;
    end
    outStream0_full = 1'b0;
    if (got_q.size() == 0) begin
      check("result_timeout", 64'(got_q.size()), 64'd1);
      d = '0;
    end else begin
      d = got_q.pop_front();
    end
  endtask

  task automatic set_ab(input int a0, input int a1, input int a2, input int a3,
                        input int b0, input int b1, input int b2, input int b3);
    va = '{a0, a1, a2, a3};
    vb = '{b0, b1, b2, b3};
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [31:0] d, exp_d;
  int base, strobes_at_rst;

  initial begin
    reset = 1'b1;
    inStream0_data = '0; inStream1_data = '0; inStream2_data = '0;
    inStream0_wr = 1'b0; inStream1_wr = 1'b0; inStream2_wr = 1'b0;
    outStream0_full = 1'b0;
    reg_simple_mul = '0; reg_shift = '0; reg_len = '0;
    tick; tick;
    check("rst_full0", 64'(inStream0_full), 0);
    check("rst_full1", 64'(inStream1_full), 0);
    check("rst_full2", 64'(inStream2_full), 0);
    check("rst_data", 64'(outStream0_data), 0);
    check("rst_wr", 64'(outStream0_wr), 0);
    check("rst_busy", 64'(busy), 0);
    reset = 1'b0;
    strobes_at_rst = n_strobes;
    tick;

    // basic dot product and its latency from the last beat
    set_ab(1, 2, 3, 4, 5, 6, 7, 8);
    base = n_strobes;
    send_vector(2, 2, 0, 32'd0, 10, 1'b0);
    wait_result(1'b0, d);
    check("dot", 64'(d), 80);
    check("dot_latency", 64'(strobe_cyc - last_wr_cyc), 1);
    repeat (4) tick;
    check("dot_one_strobe", 64'(n_strobes - base), 1);
    $display("vec dot: d=%0d", d);

    send_vector(2, 2, 2, 32'd0, 10, 1'b0);
    wait_result(1'b0, d);
    check("dot_shift2", 64'(d), 20);
    $display("vec dot_shift2: d=%0d", d);

    send_vector(2, 2, 0, 32'd3, 10, 1'b0);
    wait_result(1'b0, d);
    check("simple_mul", 64'(d), 40);
    check("simple_mul_b_full", 64'(inStream1_full), 0);
    $display("vec simple_mul: d=%0d", d);

    // zero-length vector: bias only
    send_vector(0, 0, 2, 32'd0, -16, 1'b0);
    wait_result(1'b0, d);
    check("neg_bias", 64'(d), 64'h0000_0000_FFFF_FFFC);
    check("neg_bias_latency", 64'(strobe_cyc - last_wr_cyc), 2);
    $display("vec neg_bias: d=0x%08h", d);

    // backpressure held while the result waits in OUT
    set_ab(1, 2, 0, 0, 5, 6, 0, 0);
    outStream0_full = 1'b1;
    base = n_strobes;
    send_vector(1, 1, 0, 32'd0, 10, 1'b0);
    repeat (4) tick;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("bp_wr_low", 64'(outStream0_wr), 0);
      check("bp_data", 64'(outStream0_data), 27);
      check("bp_busy", 64'(busy), 1);
      tick;
    end
    outStream0_full = 1'b0;
    @(negedge clock);
    check("bp_wr_release", 64'(outStream0_wr), 1);
    wait_result(1'b0, d);
    check("bp_result", 64'(d), 27);
    repeat (4) tick;
    check("bp_one_strobe", 64'(n_strobes - base), 1);
    $display("vec backpressure: d=%0d", d);

    // mid-vector reset after one of two beats
    set_ab(1, 2, 3, 4, 5, 6, 7, 8);
    base = n_strobes;
    send_vector(2, 1, 0, 32'd0, 10, 1'b0);
    repeat (3) tick;
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 64'(busy), 0);
    check("mid_rst_full0", 64'(inStream0_full), 0);
    check("mid_rst_full1", 64'(inStream1_full), 0);
    check("mid_rst_full2", 64'(inStream2_full), 0);
    tick;
    reset = 1'b0;
    strobes_at_rst = n_strobes;
    repeat (4) tick;
    check("mid_rst_no_strobe", 64'(n_strobes - base), 0);
    send_vector(2, 2, 0, 32'd0, 10, 1'b0);
    wait_result(1'b0, d);
    check("after_rst_dot", 64'(d), 80);
    $display("vec after_reset: d=%0d", d);

    // random vectors with register scrambling after latch and random backpressure
    for (int v = 0; v < 25; v++) begin
      int len, sh, c;
      logic [31:0] mul;
      len = $urandom_range(0, 6);
      sh  = ($urandom_range(0, 9) == 0) ? $urandom_range(64, 255) : $urandom_range(0, 40);
      mul = ($urandom_range(0, 3) == 0) ? $urandom : 32'd0;
      c   = $urandom;
      va.delete();
      vb.delete();
      for (int k = 0; k < len * LANES; k++) begin
        va.push_back($urandom);
        vb.push_back($urandom);
      end
      exp_d = model(len, sh, mul, c);
      send_vector(len, len, sh, mul, c, 1'b1);
      wait_result(1'b1, d);
      check($sformatf("rand_vec%0d", v), 64'(d), 64'(exp_d));
      $display("vec rand%0d: len=%0d shift=%0d mul=0x%08h d=0x%08h", v, len, sh, mul, d);
    end

`ifdef MULTI_DATAFLOW_MAC_LANES_MONITOR_EN
    check("mon_vec", 64'(mon_vec_count), 64'(n_strobes - strobes_at_rst));
`endif

    // c FIFO overflow: one word popped, 64 stored, the 66th write dropped
    reg_len = 16'd1;
    reg_simple_mul = '0;
    for (int i = 1; i <= 66; i++) begin
      inStream2_data = i;
      inStream2_wr   = 1'b1;
      tick;
      @(negedge clock);
      check($sformatf("ovf_full_w%0d", i), 64'(inStream2_full), 64'(i >= 65));
    end
    inStream2_wr = 1'b0;
    tick;
    check("ovf_full_end", 64'(inStream2_full), 1);
`ifdef MULTI_DATAFLOW_MAC_LANES_MONITOR_EN
    check("mon_drop", 64'(mon_drop_count), 1);
`endif
    reset = 1'b1;
    tick;
    check("ovf_rst_full2", 64'(inStream2_full), 0);
    reset = 1'b0;
    tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
